// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator: lt/eq/gt/unord flags, EQ/LT/LE predicates,
// minimumNumber/maximumNumber selection and invalid flag, with valid/ready on both sides.
module fp_cmp_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MANT_W = 23,
  localparam int unsigned W = 1 + EXP_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         lt,
  output logic         eq,
  output logic         gt,
  output logic         unord,
  output logic         nv
);

  localparam logic [2:0] OP_LT  = 3'd1;
  localparam logic [2:0] OP_LE  = 3'd2;
  localparam logic [2:0] OP_MIN = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // Operand classification on the raw inputs
  logic a_nan_c, a_snan_c, a_zero_c, b_nan_c, b_snan_c, b_zero_c;
  logic mag_lt_c, mag_eq_c;

  always_comb begin
    a_nan_c  = (&a[W-2:MANT_W]) && (|a[MANT_W-1:0]);
    b_nan_c  = (&b[W-2:MANT_W]) && (|b[MANT_W-1:0]);
    a_snan_c = a_nan_c && !a[MANT_W-1];
    b_snan_c = b_nan_c && !b[MANT_W-1];
    a_zero_c = ~|a[W-2:0];
    b_zero_c = ~|b[W-2:0];
    mag_lt_c = a[W-2:0] < b[W-2:0];
    mag_eq_c = a[W-2:0] == b[W-2:0];
  end

  logic         s1_valid, s2_valid;
  logic         s1_a_nan, s1_a_snan, s1_a_zero, s1_b_nan, s1_b_snan, s1_b_zero;
  logic         s1_mag_lt, s1_mag_eq;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;
  logic         s2_adv_c, s1_adv_c;

  always_comb begin
    s2_adv_c = !s2_valid || out_ready;
    s1_adv_c = !s1_valid || s2_adv_c;
  end

  assign in_ready  = s1_adv_c;
  assign out_valid = s2_valid;

  // Stage 1: classification and magnitude compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a_nan  <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
      s1_op     <= 3'd0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a_nan  <= a_nan_c;
        s1_a_snan <= a_snan_c;
        s1_a_zero <= a_zero_c;
        s1_b_nan  <= b_nan_c;
        s1_b_snan <= b_snan_c;
        s1_b_zero <= b_zero_c;
        s1_mag_lt <= mag_lt_c;
        s1_mag_eq <= mag_eq_c;
        s1_op     <= op;
        s1_a      <= a;
        s1_b      <= b;
      end
    end
  end

  // Ordering, predicate and min/max selection from stage-1 state
  logic         unord_c, eq_c, lt_c, gt_c, nv_c, sa_c, sb_c;
  logic [W-1:0] res_c;

  always_comb begin
    sa_c    = s1_a[W-1];
    sb_c    = s1_b[W-1];
    unord_c = s1_a_nan || s1_b_nan;
    eq_c    = !unord_c && ((s1_a_zero && s1_b_zero) || ((sa_c == sb_c) && s1_mag_eq));
    lt_c    = 1'b0;
    if (!unord_c && !eq_c) begin
      if (sa_c != sb_c) lt_c = sa_c;
      else              lt_c = sa_c ? (!s1_mag_lt && !s1_mag_eq) : s1_mag_lt;
    end
    gt_c = !unord_c && !eq_c && !lt_c;
    nv_c = s1_a_snan || s1_b_snan || (unord_c && (s1_op == OP_LT || s1_op == OP_LE));
    res_c = {{(W-1){1'b0}}, eq_c};
    case (s1_op)
      OP_LT: res_c = {{(W-1){1'b0}}, lt_c};
      OP_LE: res_c = {{(W-1){1'b0}}, lt_c || eq_c};
      OP_MIN, OP_MAX: begin
        if (s1_a_nan && s1_b_nan)          res_c = QNAN;
        else if (s1_a_nan)                 res_c = s1_b;
        else if (s1_b_nan)                 res_c = s1_a;
        else if (s1_a_zero && s1_b_zero)   res_c = ((s1_op == OP_MIN) == sa_c) ? s1_a : s1_b;
        else if (eq_c)                     res_c = s1_a;
        else                               res_c = ((s1_op == OP_MIN) == lt_c) ? s1_a : s1_b;
      end
      default: res_c = {{(W-1){1'b0}}, eq_c};
    endcase
  end

  // Stage 2: registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res      <= '0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      unord    <= 1'b0;
      nv       <= 1'b0;
    end else if (s2_adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res   <= res_c;
        lt    <= lt_c;
        eq    <= eq_c;
        gt    <= gt_c;
        unord <= unord_c;
        nv    <= nv_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Directed bench for fp_cmp_pipe in fp32: vector table, backpressure stream, mid-stream reset.
module tb_fp_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        lt, eq, gt, unord, nv;

  int checks = 0;
  int passes = 0;

  fp_cmp_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .lt(lt), .eq(eq), .gt(gt), .unord(unord), .nv(nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [4:0]  flags;  // {lt, eq, gt, unord, nv}
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Drive one pair into an empty pipe and check the result appears two edges later.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
    check($sformatf("v%0d_res", idx), res, v.res);
    check($sformatf("v%0d_flags", idx), 32'({lt, eq, gt, unord, nv}), 32'(v.flags));
  endtask

  vec_t vecs[19];
  logic [31:0] exp_q[$];
  logic [31:0] prev_res;
  logic        prev_stall;
  logic        saw_in_stall;
  int          sent, recv, cyc;
  logic        take_in, take_out;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 3'd1, 32'h00000001, 5'b10000};
    vecs[1]  = '{32'h80000000, 32'h00000000, 3'd0, 32'h00000001, 5'b01000};
    vecs[2]  = '{32'h80000000, 32'h00000000, 3'd3, 32'h80000000, 5'b01000};
    vecs[3]  = '{32'h00000000, 32'h80000000, 3'd3, 32'h80000000, 5'b01000};
    vecs[4]  = '{32'h80000000, 32'h00000000, 3'd4, 32'h00000000, 5'b01000};
    vecs[5]  = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h00000000, 5'b00010};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 3'd2, 32'h00000000, 5'b00011};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 3'd4, 32'h3F800000, 5'b00010};
    vecs[8]  = '{32'h7F800001, 32'h7FC00000, 3'd3, 32'h7FC00000, 5'b00011};
    vecs[9]  = '{32'hC0000000, 32'hBF800000, 3'd1, 32'h00000001, 5'b10000};
    vecs[10] = '{32'h00000000, 32'h00000001, 3'd1, 32'h00000001, 5'b10000};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 3'd2, 32'h00000001, 5'b01000};
    vecs[12] = '{32'h7F800000, 32'h3F800000, 3'd1, 32'h00000000, 5'b00100};
    vecs[13] = '{32'hFF800000, 32'h7F800000, 3'd3, 32'hFF800000, 5'b10000};
    vecs[14] = '{32'h40000000, 32'h40000000, 3'd5, 32'h00000001, 5'b01000};
    vecs[15] = '{32'h7FC00000, 32'h7FC00000, 3'd0, 32'h00000000, 5'b00010};
    vecs[16] = '{32'h3F800000, 32'h7F800001, 3'd4, 32'h3F800000, 5'b00011};
    vecs[17] = '{32'hC0000000, 32'h3F800000, 3'd4, 32'h3F800000, 5'b10000};
    vecs[18] = '{32'hBF800000, 32'hC0000000, 3'd1, 32'h00000000, 5'b00100};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_flags", 32'({lt, eq, gt, unord, nv}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure stream: MIN(1.0+i, 2.0) returns a, so results are distinguishable
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; saw_in_stall = 1'b0; prev_res = '0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h3F800000 + 32'(i));
    while (recv < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = sent < 6;
      a = 32'h3F800000 + 32'(sent); b = 32'h40000000; op = 3'd3;
      #1;
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_res_held", res, prev_res);
      end
      if (out_valid && !out_ready && !in_ready) saw_in_stall = 1'b1;
      take_in  = in_valid && in_ready;
      take_out = out_valid && out_ready;
      if (take_out) check($sformatf("stream_res%0d", recv), res, exp_q[recv]);
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
      @(posedge clk);
      if (take_in) sent++;
      if (take_out) recv++;
      cyc++;
    end
    check("stream_all_received", 32'(recv), 32'd6);
    check("stream_in_ready_stalled", 32'(saw_in_stall), 32'd1);

    // Mid-stream reset discards in-flight results
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h3F800000; b = 32'h40000000; op = 3'd1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
    end
    run_vec('{32'hC0000000, 32'hBF800000, 3'd4, 32'hBF800000, 5'b10000}, 99);
    @(negedge clk);
    check("post_rst_no_dup", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
